adder_rr_arbiter: RTL and testbench

- Shares one carry_lookahead_adder instance (WIDTH bits) between NUM_REQ requesters.
- Each requester presents an operand pair on a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and routes its operands into the adder.
- The adder result is captured into a single-entry output register, tagged with the requester ID, and drained on a valid/ready response interface.

---
 rtl/adder_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_arbiter (with carry_lookahead_adder)
// Description : Round-robin sharing of one prefix-carry adder among NUM_REQ
//               requesters, with a single-entry tagged response register.
// Revision    : 1.0 - initial release
// ============================================================================

module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    logic [WIDTH-1:0] w_p0;
    logic [WIDTH:0]   w_carry;

    assign w_p0 = i_a ^ i_b;

    // Kogge-Stone prefix tree; after the last level g_lvl[i] is the carry out of bit i.
    always_comb begin : b_prefix
        logic [WIDTH-1:0] w_g_lvl;
        logic [WIDTH-1:0] w_p_lvl;
        logic [WIDTH-1:0] w_g_nxt;
        logic [WIDTH-1:0] w_p_nxt;
        w_g_lvl = i_a & i_b;
        w_p_lvl = i_a ^ i_b;
        w_g_nxt = '0;
        w_p_nxt = '0;
        for (int l = 0; l < LEVELS; l++) begin
            w_g_nxt = w_g_lvl;
            w_p_nxt = w_p_lvl;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    w_g_nxt[i] = w_g_lvl[i] | (w_p_lvl[i] & w_g_lvl[i - (1 << l)]);
                    w_p_nxt[i] = w_p_lvl[i] & w_p_lvl[i - (1 << l)];
                end
            end
            w_g_lvl = w_g_nxt;
            w_p_lvl = w_p_nxt;
        end
        w_carry = {w_g_lvl, 1'b0};
    end

    assign o_sum = {w_carry[WIDTH], w_p0 ^ w_carry[WIDTH-1:0]};

endmodule

module adder_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add2,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [WIDTH:0]           o_rsp_result,
    output logic                     o_busy
);

    localparam logic [ID_W-1:0] C_LAST_RESET = ID_W'(NUM_REQ - 1);

    logic [WIDTH-1:0]   w_add1_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_add2_arr [NUM_REQ];
    logic               w_slot_free;
    logic               w_grant_found;
    logic [ID_W-1:0]    w_grant_idx;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH:0]     w_sum;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH:0]     r_rsp_result;
    logic [ID_W-1:0]    r_last_grant;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
            assign w_add1_arr[k] = i_req_add1[k*WIDTH +: WIDTH];
            assign w_add2_arr[k] = i_req_add2[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Reset low also blocks grants so no requester sees a phantom accept.
    assign w_slot_free = i_rst_n && (!r_rsp_valid || i_rsp_ready);

    always_comb begin
        int w_idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(r_last_grant) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_grant_found && i_req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(w_idx);
            end
        end
    end

    assign w_req_ready = (w_slot_free && w_grant_found) ?
                         (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_xfer      = |w_req_ready;

    assign w_op_a = w_add1_arr[w_grant_idx];
    assign w_op_b = w_add2_arr[w_grant_idx];

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_last_grant <= C_LAST_RESET;
        end else if (w_xfer) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_grant_idx;
            r_rsp_result <= w_sum;
            r_last_grant <= w_grant_idx;
        end else if (r_rsp_valid && i_rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_busy       = (|i_req_valid) || r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rr_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level reference model of the shared adder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_adder_rr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     i_clk;
    logic                     i_rst_n;
    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ*WIDTH-1:0] i_req_add1;
    logic [NUM_REQ*WIDTH-1:0] i_req_add2;
    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic [ID_W-1:0]          o_rsp_id;
    logic [WIDTH:0]           o_rsp_result;
    logic                     o_busy;

    int n_checks;
    int n_errors;

    // Reference model state (transaction level)
    logic       m_valid;
    int         m_id;
    int         m_result;
    int         m_last;
    logic [3:0] m_xfer;

    adder_rr_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_add1   (i_req_add1),
        .i_req_add2   (i_req_add2),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] model_grant();
        if (!i_rst_n) return 4'b0;
        if (m_valid && !i_rsp_ready) return 4'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int k;
            k = (m_last + off) % NUM_REQ;
            if (i_req_valid[k]) return 4'(1 << k);
        end
        return 4'b0;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 0;
        m_result = 0;
        m_last   = NUM_REQ - 1;
    endtask

    // Updates the model from the inputs presented this cycle, then moves to the next negedge.
    task automatic advance();
        m_xfer = model_grant();
        if (i_rst_n) begin
            if (m_xfer != 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (m_xfer[k]) begin
                        m_id     = k;
                        m_last   = k;
                        m_result = int'(i_req_add1[k*WIDTH +: WIDTH]) + int'(i_req_add2[k*WIDTH +: WIDTH]);
                    end
                end
                m_valid = 1'b1;
            end else if (m_valid && i_rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
        i_req_add1[k*WIDTH +: WIDTH] = a;
        i_req_add2[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic apply_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", o_rsp_valid); end
        n_checks++;
        if (o_rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_id got %0d want 0", o_rsp_id); end
        n_checks++;
        if (o_rsp_result !== 9'h000) begin n_errors++; $display("FAIL reset_result got %h want 000", o_rsp_result); end
        n_checks++;
        if (o_req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got %b want 0000", o_req_ready); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        @(negedge i_clk);
    endtask

    task automatic test_single();
        i_rsp_ready = 1'b1;
        set_ops(2, 8'h7F, 8'h01);
        i_req_valid = 4'b0100;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready got %b want 0100", o_req_ready); end
        n_checks++;
        if (o_busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got %b want 1", o_busy); end
        advance();
        i_req_valid = '0;
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %b want 1", o_rsp_valid); end
        n_checks++;
        if (o_rsp_id !== 2'd2) begin n_errors++; $display("FAIL single_id got %0d want 2", o_rsp_id); end
        n_checks++;
        if (o_rsp_result !== 9'h080) begin n_errors++; $display("FAIL single_result got %h want 080", o_rsp_result); end
        @(negedge i_clk);
        m_valid = 1'b0;
    endtask

    task automatic test_carry();
        logic [8:0] want [2];
        logic [7:0] bvals [2];
        want[0] = 9'h1FE; want[1] = 9'h100;
        bvals[0] = 8'hFF; bvals[1] = 8'h01;
        i_rsp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_ops(0, 8'hFF, bvals[t]);
            i_req_valid = 4'b0001;
            #1;
            n_checks++;
            if (o_req_ready !== 4'b0001) begin n_errors++; $display("FAIL carry_ready[%0d] got %b want 0001", t, o_req_ready); end
            advance();
            i_req_valid = '0;
            #1;
            n_checks++;
            if (o_rsp_result !== want[t] || o_rsp_id !== 2'd0) begin
                n_errors++; $display("FAIL carry_result[%0d] got %h id %0d want %h id 0", t, o_rsp_result, o_rsp_id, want[t]);
            end
            @(negedge i_clk);
            m_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_res;
        int         exp_id;
        apply_reset();
        i_rsp_ready = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) set_ops(k, 8'($urandom), 8'($urandom));
        i_req_valid = 4'b1111;
        exp_res = '0;
        exp_id  = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c > 0) begin
                n_checks++;
                if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'(exp_id) || o_rsp_result !== exp_res) begin
                    n_errors++; $display("FAIL b2b_rsp[%0d] got v%b id %0d res %h want v1 id %0d res %h",
                        c, o_rsp_valid, o_rsp_id, o_rsp_result, exp_id, exp_res);
                end
            end
            exp_id  = c % NUM_REQ;
            exp_res = 9'(i_req_add1[exp_id*WIDTH +: WIDTH]) + 9'(i_req_add2[exp_id*WIDTH +: WIDTH]);
            n_checks++;
            if (o_req_ready !== 4'(1 << exp_id)) begin
                n_errors++; $display("FAIL b2b_grant[%0d] got %b want %b", c, o_req_ready, 4'(1 << exp_id));
            end
            advance();
            set_ops(exp_id, 8'($urandom), 8'($urandom));
        end
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'(exp_id) || o_rsp_result !== exp_res) begin
            n_errors++; $display("FAIL b2b_last got v%b id %0d res %h want v1 id %0d res %h",
                o_rsp_valid, o_rsp_id, o_rsp_result, exp_id, exp_res);
        end
        i_req_valid = '0;
        @(negedge i_clk);
    endtask

    task automatic test_backpressure();
        logic [8:0] exp1;
        // Last grant is 1 here; requester 0 alone is still granted.
        i_rsp_ready = 1'b1;
        set_ops(0, 8'h12, 8'h34);
        i_req_valid = 4'b0001;
        advance();
        i_rsp_ready = 1'b0;
        set_ops(1, 8'($urandom), 8'($urandom));
        set_ops(3, 8'($urandom), 8'($urandom));
        i_req_valid = 4'b1010;
        exp1 = 9'(i_req_add1[1*WIDTH +: WIDTH]) + 9'(i_req_add2[1*WIDTH +: WIDTH]);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (o_req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d] got %b want 0000", c, o_req_ready); end
            n_checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 9'h046) begin
                n_errors++; $display("FAIL bp_hold[%0d] got v%b id %0d res %h want v1 id 0 res 046", c, o_rsp_valid, o_rsp_id, o_rsp_result);
            end
            advance();
        end
        i_rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_release_ready got %b want 0010", o_req_ready); end
        advance();
        i_req_valid = 4'b1000;
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd1 || o_rsp_result !== exp1) begin
            n_errors++; $display("FAIL bp_drain got v%b id %0d res %h want v1 id 1 res %h", o_rsp_valid, o_rsp_id, o_rsp_result, exp1);
        end
        n_checks++;
        if (o_req_ready !== 4'b1000) begin n_errors++; $display("FAIL bp_next_ready got %b want 1000", o_req_ready); end
        advance();
        i_req_valid = '0;
        @(negedge i_clk);
        m_valid = 1'b0;
    endtask

    task automatic test_rr_memory();
        apply_reset();
        i_rsp_ready = 1'b1;
        set_ops(3, 8'h05, 8'h06);
        set_ops(0, 8'h10, 8'h20);
        i_req_valid = 4'b1000;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b1000) begin n_errors++; $display("FAIL rr_first got %b want 1000", o_req_ready); end
        advance();
        i_req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (o_req_ready !== 4'b0000) begin n_errors++; $display("FAIL rr_idle_ready[%0d] got %b want 0000", c, o_req_ready); end
            advance();
        end
        n_checks++;
        if (o_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rr_idle_valid got %b want 0", o_rsp_valid); end
        i_req_valid = 4'b1001;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0001) begin n_errors++; $display("FAIL rr_pick0 got %b want 0001", o_req_ready); end
        advance();
        i_req_valid = 4'b1000;
        #1;
        n_checks++;
        if (o_rsp_id !== 2'd0 || o_rsp_result !== 9'h030) begin
            n_errors++; $display("FAIL rr_rsp0 got id %0d res %h want id 0 res 030", o_rsp_id, o_rsp_result);
        end
        n_checks++;
        if (o_req_ready !== 4'b1000) begin n_errors++; $display("FAIL rr_pick3 got %b want 1000", o_req_ready); end
        advance();
        i_req_valid = '0;
        #1;
        n_checks++;
        if (o_rsp_id !== 2'd3 || o_rsp_result !== 9'h00B) begin
            n_errors++; $display("FAIL rr_rsp3 got id %0d res %h want id 3 res 00b", o_rsp_id, o_rsp_result);
        end
        @(negedge i_clk);
        m_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        i_rsp_ready = 1'b0;
        set_ops(0, 8'h01, 8'h02);
        set_ops(1, 8'h03, 8'h04);
        i_req_valid = 4'b0001;
        advance();
        i_req_valid = 4'b0011;
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b1) begin n_errors++; $display("FAIL ar_pending got %b want 1", o_rsp_valid); end
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_rsp_result !== 9'h000 || o_rsp_id !== 2'd0) begin
            n_errors++; $display("FAIL ar_async got v%b id %0d res %h want v0 id 0 res 000", o_rsp_valid, o_rsp_id, o_rsp_result);
        end
        n_checks++;
        if (o_req_ready !== 4'b0000) begin n_errors++; $display("FAIL ar_ready_in_reset got %b want 0000", o_req_ready); end
        @(negedge i_clk);
        advance();
        i_rst_n     = 1'b1;
        i_rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0001) begin n_errors++; $display("FAIL ar_priority got %b want 0001", o_req_ready); end
        advance();
        i_req_valid = 4'b0010;
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_result !== 9'h003) begin
            n_errors++; $display("FAIL ar_rsp got v%b id %0d res %h want v1 id 0 res 003", o_rsp_valid, o_rsp_id, o_rsp_result);
        end
        advance();
        i_req_valid = '0;
        advance();
    endtask

    task automatic test_random();
        logic [3:0] exp_ready;
        for (int k = 0; k < NUM_REQ; k++) set_ops(k, 8'($urandom), 8'($urandom));
        i_req_valid = 4'($urandom);
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            #1;
            exp_ready = model_grant();
            n_checks++;
            if (o_req_ready !== exp_ready) begin
                n_errors++; $display("FAIL rnd_ready[%0d] got %b want %b", c, o_req_ready, exp_ready);
            end
            n_checks++;
            if (o_rsp_valid !== m_valid) begin
                n_errors++; $display("FAIL rnd_valid[%0d] got %b want %b", c, o_rsp_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (o_rsp_id !== 2'(m_id) || o_rsp_result !== 9'(m_result)) begin
                    n_errors++; $display("FAIL rnd_rsp[%0d] got id %0d res %h want id %0d res %h",
                        c, o_rsp_id, o_rsp_result, m_id, 9'(m_result));
                end
            end
            n_checks++;
            if (o_busy !== ((|i_req_valid) || m_valid)) begin
                n_errors++; $display("FAIL rnd_busy[%0d] got %b want %b", c, o_busy, (|i_req_valid) || m_valid);
            end
            advance();
            // Requests hold until accepted; idle or finished requesters may re-roll.
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_xfer[k] || !i_req_valid[k]) begin
                    i_req_valid[k] = ($urandom_range(99) < 60);
                    set_ops(k, 8'($urandom), 8'($urandom));
                end
            end
            i_rsp_ready = ($urandom_range(99) < 70);
        end
        i_req_valid = '0;
        i_rsp_ready = 1'b1;
        advance();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_add1  = '0;
        i_req_add2  = '0;
        i_rsp_ready = 1'b0;
        m_xfer      = '0;
        model_reset();
        @(negedge i_clk);
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_rr_memory();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
